// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: instruction field positions,
// next-PC select encodings and the fetch FSM state type.
package mips_pkg;

   localparam int OP_W      = 6;
   localparam int FUNCT_W   = 6;
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int JIDX_MSB  = 25;
   localparam int IMM_MSB   = 15;

   localparam logic [1:0] PC_NEXT_SEQ = 2'b00;
   localparam logic [1:0] PC_NEXT_BR  = 2'b01;
   localparam logic [1:0] PC_NEXT_J   = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      REQ   = 2'b01,
      VALID = 2'b10
   } fetch_state_e;

   // Sign-extended branch immediate, already scaled to a byte offset.
   function automatic logic [31:0] branch_offset(input logic [JIDX_MSB:0] ins);
      return {{14{ins[IMM_MSB]}}, ins[IMM_MSB:0], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch or
// pseudo-direct jump. Jump takes priority when both selects are set.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0]       pc,
   input  logic [JIDX_MSB:0] instr,
   input  logic [1:0]        pc_next_c,
   output logic [31:0]       pc_plus4,
   output logic [31:0]       pc_next
);

   assign pc_plus4 = pc + 32'd4;

   // Select the address of the next instruction to fetch.
   always_comb begin
      pc_next = pc_plus4;
      case (pc_next_c)
         PC_NEXT_SEQ:      pc_next = pc_plus4;
         PC_NEXT_BR:       pc_next = pc_plus4 + branch_offset(instr);
         PC_NEXT_J, 2'b11: pc_next = {pc_plus4[31:28], instr[JIDX_MSB:0], 2'b00};
         default:          pc_next = pc_plus4;
      endcase
   end

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// instruction until the datapath retires it, and counts retired instructions.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        instr,
   output logic [OP_W-1:0]    op_c,
   output logic [FUNCT_W-1:0] funct,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic [1:0]         pc_next_c,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   output logic [CNT_W-1:0]   retired_cnt
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   fetch_state_e     state_r;
   logic [31:0]      pc_r;
   logic [31:0]      instr_r;
   logic             req_r;
   logic             valid_r;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      pc_plus4_s;
   logic [31:0]      pc_next_s;

   next_pc_calc u_next_pc_calc (
      .pc        (pc_r),
      .instr     (instr_r[JIDX_MSB:0]),
      .pc_next_c (pc_next_c),
      .pc_plus4  (pc_plus4_s),
      .pc_next   (pc_next_s)
   );

   // Fetch FSM; req/valid are registered alongside the state they mirror.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         pc_r    <= RESET_PC_ALIGNED;
         instr_r <= 32'h0000_0000;
         req_r   <= 1'b0;
         valid_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= REQ;
               req_r   <= 1'b1;
            end
            REQ: begin
               if (imem_ack) begin
                  instr_r <= imem_rdata;
                  state_r <= VALID;
                  req_r   <= 1'b0;
                  valid_r <= 1'b1;
               end
            end
            VALID: begin
               // Acks seen here are protocol errors and never touch instr_r.
               if (instr_ready) begin
                  pc_r    <= pc_next_s;
                  cnt_r   <= cnt_r + CNT_W'(1);
                  state_r <= REQ;
                  req_r   <= 1'b1;
                  valid_r <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               req_r   <= 1'b0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_r;
   assign imem_addr   = pc_r;
   assign instr       = instr_r;
   assign op_c        = instr_r[OP_MSB:OP_LSB];
   assign funct       = instr_r[FUNCT_MSB:0];
   assign instr_valid = valid_r;
   assign pc          = pc_r;
   assign pc_plus4    = pc_plus4_s;
   assign retired_cnt = cnt_r;

endmodule
